traffic_light_monitor: RTL

Passive observer on the outputs of the traffic-light controller, the consuming end of the main_road/side_road interface. It samples both light lines, reconstructs the current phase, and measures phase durations in clock cycles. It raises sticky timing and safety violation flags for the bench and for on-chip status. It never drives the light lines.

---
 rtl/traffic_light_monitor.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/traffic_light_monitor.sv
// Passive monitor for the main/side traffic-light lines. It rebuilds the current phase,
// measures how long each phase lasts, and keeps sticky timing/safety violation flags.
module traffic_light_monitor #(
  parameter int unsigned MIN_GREEN      = 3,
  parameter int unsigned MAX_GREEN      = 8,
  parameter int unsigned MAX_ALLRED     = 2,
  parameter int unsigned REQUIRE_ALLRED = 0,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned GCNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              main_road,
  input  logic              side_road,
  input  logic              err_clr,
  output logic [1:0]        phase,
  output logic [CNT_W-1:0]  run_len,
  output logic              phase_done,
  output logic [1:0]        last_phase,
  output logic [CNT_W-1:0]  last_len,
  output logic [GCNT_W-1:0] green_count,
  output logic              conflict_err,
  output logic              short_err,
  output logic              long_err,
  output logic              allred_err,
  output logic              seq_err,
  output logic              err_any
);

  typedef enum logic [1:0] {StInit, StFirst, StTrack} state_e;

  localparam logic [1:0]       PhAllRed   = 2'b00;
  localparam logic [1:0]       PhMain     = 2'b01;
  localparam logic [1:0]       PhSide     = 2'b10;
  localparam logic [1:0]       PhConflict = 2'b11;
  localparam logic [CNT_W-1:0] CntMax     = '1;
  localparam logic [CNT_W:0]   MinLen     = (CNT_W+1)'(MIN_GREEN);
  localparam logic [CNT_W:0]   LongLen    = (CNT_W+1)'(MAX_GREEN + 1);
  localparam logic [CNT_W:0]   AllRedLen  = (CNT_W+1)'(MAX_ALLRED + 1);

  logic              s_main_q, s_side_q, s_valid_q;
  state_e            state_q, state_d;
  logic [1:0]        phase_q, phase_d, last_phase_q, last_phase_d;
  logic [CNT_W-1:0]  run_len_q, run_len_d, last_len_q, last_len_d;
  logic              phase_done_q, phase_done_d;
  logic [GCNT_W-1:0] green_count_q, green_count_d;
  logic              conflict_q, short_q, long_q, allred_q, seq_q, err_any_q;
  logic              ev_conflict, ev_short, ev_long, ev_allred, ev_seq;
  logic [1:0]        cur;
  logic              cur_green, old_green;

  assign cur       = {s_side_q, s_main_q};
  assign cur_green = (cur == PhMain) || (cur == PhSide);
  assign old_green = (phase_q == PhMain) || (phase_q == PhSide);

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    run_len_d     = run_len_q;
    phase_done_d  = 1'b0;
    last_phase_d  = last_phase_q;
    last_len_d    = last_len_q;
    green_count_d = green_count_q;
    ev_conflict   = 1'b0;
    ev_short      = 1'b0;
    ev_long       = 1'b0;
    ev_allred     = 1'b0;
    ev_seq        = 1'b0;
    // The tracker idles until the input sample stage holds a real post-reset value.
    if (s_valid_q) begin
      ev_conflict = (cur == PhConflict);
      unique case (state_q)
        StInit: begin
          phase_d   = cur;
          run_len_d = CNT_W'(1);
          state_d   = StFirst;
        end
        StFirst, StTrack: begin
          if (cur == phase_q) begin
            run_len_d = (run_len_q == CntMax) ? run_len_q : run_len_q + CNT_W'(1);
          end else begin
            phase_d      = cur;
            run_len_d    = CNT_W'(1);
            phase_done_d = 1'b1;
            last_phase_d = phase_q;
            last_len_d   = run_len_q;
            state_d      = StTrack;
            // The first phase was only partly observed, so its length proves nothing.
            if ((state_q == StTrack) && old_green) begin
              green_count_d = green_count_q + GCNT_W'(1);
              ev_short      = ({1'b0, run_len_q} < MinLen);
            end
            ev_seq = (REQUIRE_ALLRED != 0) && old_green && cur_green;
          end
          ev_long   = cur_green && ({1'b0, run_len_d} == LongLen);
          ev_allred = (cur == PhAllRed) && ({1'b0, run_len_d} == AllRedLen);
        end
        default: state_d = StInit;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_main_q      <= 1'b0;
      s_side_q      <= 1'b0;
      s_valid_q     <= 1'b0;
      state_q       <= StInit;
      phase_q       <= PhAllRed;
      run_len_q     <= '0;
      phase_done_q  <= 1'b0;
      last_phase_q  <= PhAllRed;
      last_len_q    <= '0;
      green_count_q <= '0;
      conflict_q    <= 1'b0;
      short_q       <= 1'b0;
      long_q        <= 1'b0;
      allred_q      <= 1'b0;
      seq_q         <= 1'b0;
      err_any_q     <= 1'b0;
    end else begin
      s_main_q      <= main_road;
      s_side_q      <= side_road;
      s_valid_q     <= 1'b1;
      state_q       <= state_d;
      phase_q       <= phase_d;
      run_len_q     <= run_len_d;
      phase_done_q  <= phase_done_d;
      last_phase_q  <= last_phase_d;
      last_len_q    <= last_len_d;
      green_count_q <= green_count_d;
      // A fresh event outranks a simultaneous clear.
      conflict_q    <= (conflict_q & ~err_clr) | ev_conflict;
      short_q       <= (short_q & ~err_clr) | ev_short;
      long_q        <= (long_q & ~err_clr) | ev_long;
      allred_q      <= (allred_q & ~err_clr) | ev_allred;
      seq_q         <= (seq_q & ~err_clr) | ev_seq;
      err_any_q     <= conflict_q | short_q | long_q | allred_q | seq_q;
    end
  end

  assign phase        = phase_q;
  assign run_len      = run_len_q;
  assign phase_done   = phase_done_q;
  assign last_phase   = last_phase_q;
  assign last_len     = last_len_q;
  assign green_count  = green_count_q;
  assign conflict_err = conflict_q;
  assign short_err    = short_q;
  assign long_err     = long_q;
  assign allred_err   = allred_q;
  assign seq_err      = seq_q;
  assign err_any      = err_any_q;

endmodule
